// File: rtl/bist_pattern_engine.sv
// LFSR-driven BIST pattern generator with a MISR response compactor and a golden-signature check.
// Sits beside an arithmetic utility block behind a test mux.
module bist_pattern_engine #(
    parameter int unsigned               WORD_WIDTH   = 8,
    parameter int unsigned               RESULT_WIDTH = 8,
    parameter logic [2*WORD_WIDTH-1:0]   LFSR_TAPS    = 16'hB400,
    parameter logic [RESULT_WIDTH-1:0]   SIG_TAPS     = 8'hB8,
    parameter int unsigned               COUNT_WIDTH  = 16,
    parameter int unsigned               DUT_LATENCY  = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [2*WORD_WIDTH-1:0]   seed,
    input  logic [COUNT_WIDTH-1:0]    test_count,
    input  logic [RESULT_WIDTH-1:0]   golden,
    output logic [WORD_WIDTH-1:0]     pattern_a,
    output logic [WORD_WIDTH-1:0]     pattern_b,
    output logic                      pattern_valid,
    input  logic [RESULT_WIDTH-1:0]   dut_result,
    output logic                      busy,
    output logic                      done,
    output logic [RESULT_WIDTH-1:0]   signature,
    output logic                      pass
);

    localparam int unsigned LfsrWidth = 2 * WORD_WIDTH;
    localparam int unsigned PipeWidth = (DUT_LATENCY > 0) ? DUT_LATENCY : 1;
    localparam logic [3:0]  DrainLast = 4'((DUT_LATENCY > 0) ? DUT_LATENCY - 1 : 0);
    localparam logic [LfsrWidth-1:0]   LfsrOne = 1;
    localparam logic [COUNT_WIDTH-1:0] CntOne  = 1;

    typedef enum logic [2:0] {StIdle, StLoad, StRun, StDrain, StDone} state_e;

    // With no response latency there is nothing to drain after the last pattern.
    localparam state_e StAfterRun = (DUT_LATENCY > 0) ? StDrain : StDone;

    state_e                  state_q, state_d;
    logic [LfsrWidth-1:0]    lfsr_q, lfsr_d;
    logic [COUNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [COUNT_WIDTH-1:0]  limit_q, limit_d;
    logic [3:0]              drain_q, drain_d;
    logic [PipeWidth-1:0]    pipe_q, pipe_d;
    logic [RESULT_WIDTH-1:0] sig_q, sig_d;
    logic                    pass_q, pass_d;
    logic                    valid_q, busy_q, done_q;
    logic                    dly_valid;

    // Response for a pattern arrives DUT_LATENCY cycles after the pattern itself.
    assign dly_valid = (DUT_LATENCY == 0) ? valid_q : pipe_q[PipeWidth-1];

    // Next-state, LFSR, counters, MISR and pass flag.
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        limit_d = limit_q;
        drain_d = drain_q;
        sig_d   = sig_q;
        pass_d  = pass_q;
        pipe_d  = pipe_q;

        pipe_d[0] = valid_q;
        for (int i = 1; i < PipeWidth; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        if (dly_valid) begin
            sig_d = {sig_q[RESULT_WIDTH-2:0], ^(sig_q & SIG_TAPS)} ^ dut_result;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                    // An all-zero state would lock the LFSR.
                    lfsr_d  = (seed == '0) ? LfsrOne : seed;
                    limit_d = test_count;
                end
            end
            StLoad: begin
                sig_d   = '0;
                pass_d  = 1'b0;
                cnt_d   = '0;
                pipe_d  = '0;
                drain_d = '0;
                state_d = (limit_q != '0) ? StRun : StAfterRun;
            end
            StRun: begin
                lfsr_d  = {lfsr_q[LfsrWidth-2:0], ^(lfsr_q & LFSR_TAPS)};
                cnt_d   = cnt_q + CntOne;
                drain_d = '0;
                if ((cnt_q + CntOne) == limit_q) begin
                    state_d = StAfterRun;
                end
            end
            StDrain: begin
                drain_d = drain_q + 4'd1;
                if (drain_q == DrainLast) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Compare on the edge entering DONE so pass is valid alongside done.
        if (state_d == StDone && state_q != StDone) begin
            pass_d = (sig_d == golden);
        end

        // Abort overrides everything; the partial signature is kept for debug.
        if (abort) begin
            state_d = StIdle;
            lfsr_d  = lfsr_q;
            limit_d = limit_q;
            sig_d   = sig_q;
            pipe_d  = '0;
            pass_d  = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers and registered status outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q  <= '0;
            cnt_q   <= '0;
            limit_q <= '0;
            drain_q <= '0;
            pipe_q  <= '0;
            sig_q   <= '0;
            pass_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            limit_q <= limit_d;
            drain_q <= drain_d;
            pipe_q  <= pipe_d;
            sig_q   <= sig_d;
            pass_q  <= pass_d;
            valid_q <= (state_d == StRun);
            busy_q  <= (state_d == StLoad) || (state_d == StRun) || (state_d == StDrain);
            done_q  <= (state_d == StDone);
        end
    end

    assign pattern_a     = lfsr_q[LfsrWidth-1:WORD_WIDTH];
    assign pattern_b     = lfsr_q[WORD_WIDTH-1:0];
    assign pattern_valid = valid_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign signature     = sig_q;
    assign pass          = pass_q;

endmodule

// File: tb/tb_bist_pattern_engine.sv
// Self-checking bench for bist_pattern_engine: directed cases plus random runs against
// a cycle-indexed reference of the pattern stream, run timeline and MISR signature.
module tb_bist_pattern_engine;

    localparam int unsigned LAT = 1;
    localparam logic [15:0] LTAPS = 16'hB400;
    localparam logic [7:0]  STAPS = 8'hB8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] seed = '0;
    logic [15:0] test_count = '0;
    logic [7:0]  golden = '0;
    logic [7:0]  dut_result = '0;
    logic [7:0]  pattern_a, pattern_b, signature;
    logic        pattern_valid, busy, done, pass;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0]  resp [0:127];
    logic [15:0] pat  [0:63];

    always #5 clk = ~clk;

    bist_pattern_engine #(
        .WORD_WIDTH   (8),
        .RESULT_WIDTH (8),
        .LFSR_TAPS    (LTAPS),
        .SIG_TAPS     (STAPS),
        .COUNT_WIDTH  (16),
        .DUT_LATENCY  (LAT)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .seed          (seed),
        .test_count    (test_count),
        .golden        (golden),
        .pattern_a     (pattern_a),
        .pattern_b     (pattern_b),
        .pattern_valid (pattern_valid),
        .dut_result    (dut_result),
        .busy          (busy),
        .done          (done),
        .signature     (signature),
        .pass          (pass)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Shift left, feedback bit is the parity of the tapped bits.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return 16'((s << 1) | 16'($countones(s & LTAPS) % 2));
    endfunction

    function automatic logic [7:0] misr_step(input logic [7:0] s, input logic [7:0] r);
        return 8'((s << 1) | 8'($countones(s & STAPS) % 2)) ^ r;
    endfunction

    // One run: start at edge 0, then check every cycle against the expected timeline.
    task automatic run_case(input logic [15:0] s, input int n, input bit gold_match,
                            input logic [7:0] gold_alt, input int abort_cyc,
                            input int dup_start_cyc, input bit rand_resp,
                            input logic [7:0] cresp);
        int          last;
        int          end_c;
        logic [15:0] p;
        logic [7:0]  sig_full;
        logic [7:0]  sig_part;
        bit          aborted, exp_busy, exp_valid, exp_done;

        last  = 2 + n + LAT;
        end_c = (abort_cyc > 0) ? abort_cyc + 4 : last + 2;
        for (int c = 0; c < 128; c++) begin
            resp[c] = rand_resp ? 8'($urandom) : cresp;
        end
        p = (s == 16'h0000) ? 16'h0001 : s;
        for (int k = 0; k < n; k++) begin
            pat[k] = p;
            p = lfsr_step(p);
        end
        sig_full = '0;
        sig_part = '0;
        for (int k = 0; k < n; k++) begin
            sig_full = misr_step(sig_full, resp[2 + k + LAT]);
            if (2 + k + LAT < abort_cyc) begin
                sig_part = misr_step(sig_part, resp[2 + k + LAT]);
            end
        end

        @(negedge clk);
        seed       = s;
        test_count = 16'(n);
        golden     = gold_match ? sig_full : gold_alt;
        start      = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= end_c; c++) begin
            #1;
            start = (c == dup_start_cyc);
            if (start) begin
                seed       = 16'($urandom);
                test_count = 16'($urandom_range(1, 200));
            end
            abort      = (c == abort_cyc);
            dut_result = resp[c];
            @(negedge clk);
            aborted   = (abort_cyc > 0) && (c > abort_cyc);
            exp_busy  = !aborted && (c <= 1 + n + LAT);
            exp_valid = !aborted && (c >= 2) && (c <= 1 + n);
            exp_done  = !aborted && (c == last);
            check("busy", 32'(busy), 32'(exp_busy));
            check("pattern_valid", 32'(pattern_valid), 32'(exp_valid));
            check("done", 32'(done), 32'(exp_done));
            if (exp_valid) begin
                check("pattern", 32'({pattern_a, pattern_b}), 32'(pat[c-2]));
            end
            if (exp_done || (abort_cyc == 0 && c > last)) begin
                check("signature", 32'(signature), 32'(sig_full));
                check("pass", 32'(pass), 32'(golden == sig_full));
            end
            if (aborted) begin
                check("abort_signature", 32'(signature), 32'(sig_part));
                check("abort_pass", 32'(pass), 32'(0));
            end
            @(posedge clk);
        end
        #1;
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pattern"}, 32'({pattern_a, pattern_b}), 32'(0));
        check({tag, "_valid"}, 32'(pattern_valid), 32'(0));
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_done"}, 32'(done), 32'(0));
        check({tag, "_signature"}, 32'(signature), 32'(0));
        check({tag, "_pass"}, 32'(pass), 32'(0));
    endtask

    // Asynchronous reset in the middle of RUN, then make sure no done ever appears.
    task automatic reset_mid_run();
        @(negedge clk);
        seed       = 16'h1234;
        test_count = 16'd30;
        golden     = '0;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dut_result = 8'h5A;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("rst_no_done", 32'(done), 32'(0));
            check("rst_idle_busy", 32'(busy), 32'(0));
        end
    endtask

    initial begin
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Seed sequence, zero responses, golden 0.
        run_case(16'h0001, 12, 1'b1, 8'h00, 0, 0, 1'b0, 8'h00);
        // Single pattern, constant response 01, matching and non-matching golden.
        run_case(16'hBEEF, 1, 1'b1, 8'h00, 0, 0, 1'b0, 8'h01);
        run_case(16'hBEEF, 1, 1'b0, 8'h02, 0, 0, 1'b0, 8'h01);
        // Zero seed, zero count.
        run_case(16'h0000, 3, 1'b1, 8'h00, 0, 0, 1'b1, 8'h00);
        run_case(16'h4321, 0, 1'b0, 8'hFF, 0, 0, 1'b1, 8'h00);
        // Abort on the 5th RUN cycle (cycle 6), then start while busy.
        run_case(16'hACE1, 20, 1'b1, 8'h00, 6, 0, 1'b1, 8'h00);
        run_case(16'h5A5A, 10, 1'b0, 8'h3C, 0, 4, 1'b1, 8'h00);

        reset_mid_run();

        for (int i = 0; i < 12; i++) begin
            run_case(16'($urandom), int'($urandom_range(0, 40)), 1'($urandom % 2),
                     8'($urandom), 0, 0, 1'b1, 8'h00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
